// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding the UART transmitter over the newd/dintx/donetx handshake.
// Optional sticky overflow flag is built when UART_TX_BUFFER_OVF_EN is defined.
module uart_tx_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              newd,
  output logic [7:0]        dintx,
  input  logic              donetx,
  output logic              ovf
);

  // Handshake: newd is a one-cycle start pulse with dintx valid and held until
  // the transmitter answers with a donetx pulse; donetx is only accepted in WAIT
  // after newd has dropped, so a stale pulse can never acknowledge a new byte.
  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state, state_next;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              push, pop, ack;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign push  = wr_en && !full;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    ack        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (!newd && donetx) begin
          ack        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      newd   <= 1'b0;
      busy   <= 1'b0;
      dintx  <= 8'h00;
    end else begin
      state <= state_next;
      newd  <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        dintx  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
        busy   <= 1'b1;
      end else if (ack) begin
        busy <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef UART_TX_BUFFER_OVF_EN
  always_ff @(posedge clk) begin
    if (rst)                ovf <= 1'b0;
    else if (wr_en && full) ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed + randomized bench for uart_tx_buffer against a queue-based
// reference of the buffer contents and the byte in flight.
module tb_uart_tx_buffer;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              donetx = 1'b0;
  logic              full, empty, busy, newd, ovf;
  logic [ADDR_W:0]   count;
  logic [7:0]        dintx;

  int tests = 0;
  int fails = 0;

  // reference: bytes waiting, byte in flight, sticky overflow
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  bit         m_busy, m_newd, m_ovf;
  logic [7:0] m_dintx;

  uart_tx_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .busy(busy),
    .newd(newd), .dintx(dintx), .donetx(donetx), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("newd", 32'(newd), 32'(m_newd));
    chk("dintx", 32'(dintx), 32'(m_dintx));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    if (newd === 1'b1) begin
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("sb_order", 32'(dintx), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_busy  = 1'b0;
    m_newd  = 1'b0;
    m_ovf   = 1'b0;
    m_dintx = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; donetx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic step(input logic we, input logic [7:0] wd, input logic dn);
    bit pre_full;
    wr_en = we; wr_data = wd; donetx = dn;
    @(posedge clk);
    pre_full = (mq.size() == DEPTH);
`ifdef UART_TX_BUFFER_OVF_EN
    if (we && pre_full) m_ovf = 1'b1;
`endif
    if (!m_busy) begin
      if (mq.size() > 0) begin
        m_dintx = mq.pop_front();
        m_busy  = 1'b1;
        m_newd  = 1'b1;
      end
    end else if (m_newd) begin
      m_newd = 1'b0;
    end else if (dn) begin
      m_busy = 1'b0;
    end
    if (we && !pre_full) begin
      mq.push_back(wd);
      exp_q.push_back(wd);
    end
    #1;
    check_outputs();
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_busy || mq.size() > 0) && guard < 2000) begin
      step(1'b0, 8'h00, m_busy && !m_newd);
      guard++;
    end
    chk("drain_timeout", 32'(guard < 2000), 32'd1);
  endtask

  initial begin
    int c_before;
    int pushed;
    int guard;
    logic we;

    // reset
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);

    // single byte, 2-cycle write-to-start latency
    step(1'b1, 8'hA5, 1'b0);
    chk("single_count1", 32'(count), 32'd1);
    chk("single_nonewd", 32'(newd), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("single_newd", 32'(newd), 32'd1);
    chk("single_dintx", 32'(dintx), 32'hA5);
    step(1'b0, 8'h00, 1'b0);
    chk("single_newd_drop", 32'(newd), 32'd0);
    chk("single_busy", 32'(busy), 32'd1);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("single_busy_drop", 32'(busy), 32'd0);
    step(1'b0, 8'h00, 1'b0);

    // fill with stalled transmitter, then overflow
    for (int i = 0; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    step(1'b1, 8'hFF, 1'b0);
    chk("ovf_count", 32'(count), 32'd16);
`ifdef UART_TX_BUFFER_OVF_EN
    chk("ovf_flag", 32'(ovf), 32'd1);
`else
    chk("ovf_flag", 32'(ovf), 32'd0);
`endif
    drain();
    chk("fill_drained", 32'(empty), 32'd1);

    // 40-byte stream with writes on pop edges (wraps pointers)
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
    pushed = 0; guard = 0;
    while (pushed < 40 && guard < 2000) begin
      we = !m_busy && (mq.size() > 0);
      c_before = int'(count);
      step(we, 8'($urandom), m_busy && !m_newd);
      if (we) begin
        chk("coincident_count", 32'(count), 32'(c_before));
        pushed++;
      end
      guard++;
    end
    chk("stream_timeout", 32'(guard < 2000), 32'd1);
    drain();

    // randomized traffic: dense writes, then sparse writes, random donetx
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0));
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 2) == 0));
    drain();

    // reset mid-frame with 5 bytes queued, then a late donetx
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_count", 32'(count), 32'd5);
    do_reset();
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_newd", 32'(newd), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("post_rst_newd2", 32'(newd), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte FIFO that sits directly upstream of the UART transmitter inside the UART top level. It accepts bytes from the host side at up to one per clock. It hands them to the transmitter one at a time over the `newd`/`dintx`/`donetx` handshake, so the host never has to wait for a frame to finish. It replaces the direct host drive of `newd`/`dintx`.

## Interface
- `DEPTH`, 16: number of byte entries; must be a power of two, at least 2.
- `ADDR_W`, 4: log2(DEPTH); the pointer width.
- `clk` input 1: the only clock.
- `rst` input 1: reset, synchronous and active-high.
- `wr_en` input 1: push `wr_data` on this edge.
- `wr_data` input 8: byte to enqueue.
- `full` output 1: high when count == DEPTH.
- `empty` output 1: high when count == 0.
- `count` output ADDR_W+1: number of stored bytes, 0..DEPTH. This excludes the byte currently being transmitted.
- `busy` output 1: high while a byte is handed to the transmitter and not yet acknowledged.
- `newd` output 1: one-cycle start pulse to the transmitter.
- `dintx` output 8: byte to transmit; held stable from the `newd` cycle until acknowledge.
- `donetx` input 1: transmitter frame-complete pulse.
- `ovf` output 1: sticky overflow flag. Present only with the macro; tied 0 otherwise.

## Operation
- Storage: DEPTH×8 register array. `wr_ptr` and `rd_ptr` are ADDR_W bits and wrap modulo DEPTH. `count` is a separate ADDR_W+1-bit register.
- Push:
  - Occurs when `wr_en` && !`full`. Writes `mem[wr_ptr]`, then increments `wr_ptr`.
  - A push while `full` is dropped: no pointer or count change.
- The FSM has two states, IDLE and WAIT.
- IDLE:
  - If count != 0: pop. Load `dintx` <= `mem[rd_ptr]`, increment `rd_ptr`, set `newd` <= 1, set `busy` <= 1, go to WAIT.
  - `donetx` is ignored in IDLE.
- WAIT:
  - `newd` <= 0 on the first edge.
  - `donetx` is ignored while `newd` is high.
  - After that, `donetx` == 1 sets `busy` <= 0 and returns to IDLE.
- Simultaneous push and pop on the same edge: `count` is unchanged. A push while `full` in the same edge as a pop is still dropped, because `full` is evaluated on the pre-edge count.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Reset, including mid-frame:
  - `wr_ptr`, `rd_ptr`, `count` = 0; state = IDLE.
  - `newd` = 0, `busy` = 0, `dintx` = 8'h00, `ovf` = 0.
  - `empty` = 1, `full` = 0.
  - Stored data is discarded. A frame the transmitter already started completes on the line. Its `donetx` arrives in IDLE and is ignored.

## Timing
- All outputs are registered, except `full` and `empty`, which are decoded from the `count` register.
- Write into an empty buffer at edge E0:
  - `count` = 1 after E0.
  - IDLE pops at E1, so `newd` is high for E1..E2 and `count` returns to 0.
  - Write-to-start latency is 2 cycles.
- Back-to-back frames: `donetx` sampled at edge En returns the FSM to IDLE. The next pop is at En+1, so there is 1 idle cycle between `donetx` and the next `newd`.
- `newd` is exactly one cycle wide. `dintx` never changes while `busy` is high.
- Throughput is bounded by the transmitter: one byte per frame time plus 2 cycles.

## Configuration
- Macro: `UART_TX_BUFFER_OVF_EN`.
- Defined:
  - `ovf` is set on any edge where `wr_en` && `full`.
  - It stays set until `rst`; there is no other clear.
- Undefined:
  - `ovf` is driven constant 0 and the detection logic is not built.
  - Dropped writes are silent.
  - The port list is identical in both builds.

## Test plan
- Reset: hold `rst` 2 cycles → `count`=0, `empty`=1, `full`=0, `newd`=0, `busy`=0, `dintx`=8'h00, `ovf`=0.
- Single byte: write 8'hA5 at E0 → `newd` high for exactly one cycle after E1, with `dintx`=8'hA5. `busy` stays high until `donetx` pulses, then drops.
- Fill and order: with the transmitter model stalled (no `donetx`), write 8'h00..8'h10 (17 bytes, DEPTH=16). First byte popped → `count` reaches 16 and `full`=1. Bytes then appear on `dintx` in order 8'h00..8'h10 with 1 idle cycle between `donetx` and each `newd`.
- Overflow: while `full`, write 8'hFF → `count` stays 16, 8'hFF is never transmitted, `ovf`=1 with the macro and 0 without.
- Wrap and simultaneous push/pop: stream 40 bytes with writes coinciding with pop edges → `count` is unchanged on coincident edges, and the pointers wrap with no loss or duplication (scoreboard match).
- Reset mid-frame: assert `rst` while `busy`=1 with 5 bytes queued, then pulse `donetx` → state stays IDLE, `newd` is not asserted, `count`=0.
